// File: rtl/pipelined_control_unit.sv
// Pipelined RV32I control unit: decodes in D, carries the control word through E/M/W, resolves branches in E.
// Optional macro MUL_EXT_EN enables decoding of the RV32M multiply group (funct7=0000001, funct3 000-011).
module pipelined_control_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] instr_d,
    input  logic             stall_e,
    input  logic             flush_e,
    input  logic             flush_m,
    input  logic             zero_e,
    input  logic             lt_e,
    input  logic             ltu_e,
    output logic [2:0]       imm_src_d,
    output logic             rs1_used_d,
    output logic             rs2_used_d,
    output logic [3:0]       alu_ctrl_e,
    output logic             alu_src_e,
    output logic             pc_src_e,
    output logic             jalr_e,
    output logic [1:0]       result_src_e,
    output logic             reg_write_m,
    output logic             mem_write_m,
    output logic [1:0]       result_src_w,
    output logic             reg_write_w,
    output logic             illegal_e,
    output logic [CNT_W-1:0] retired_cnt
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;

    typedef struct packed {
        logic       valid;
        logic       illegal;
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic       alu_src;
        logic [3:0] alu_ctrl;
        logic [2:0] funct3;
    } ctrl_t;

    // Shared R/I-ALU op mapping; only R-type may select sub, both may select sra.
    function automatic logic [3:0] aluOp(input logic [2:0] f3, input logic alt, input logic isReg);
        case (f3)
            3'b000:  aluOp = (isReg && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  aluOp = 4'b0111;
            3'b010:  aluOp = 4'b0101;
            3'b011:  aluOp = 4'b0110;
            3'b100:  aluOp = 4'b0100;
            3'b101:  aluOp = alt ? 4'b1001 : 4'b1000;
            3'b110:  aluOp = 4'b0011;
            default: aluOp = 4'b0010;
        endcase
    endfunction

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic       w_unused;
    logic       w_bad;
    logic       w_cond;
    logic       w_retire;
    ctrl_t      w_dec;

    ctrl_t      r_eCtrl;
    logic       r_mValid;
    logic       r_mIllegal;
    logic       r_mRegWrite;
    logic       r_mMemWrite;
    logic [1:0] r_mResultSrc;
    logic       r_wRegWrite;
    logic [1:0] r_wResultSrc;
    logic [CNT_W-1:0] r_retiredCnt;

    assign w_opcode = instr_d[6:0];
    assign w_funct3 = instr_d[14:12];
    assign w_funct7 = instr_d[31:25];
    assign w_unused = ^instr_d;

    // Undecodable words collapse to a bubble that still carries valid/illegal.
    always_comb begin
        w_dec        = '0;
        w_bad        = 1'b0;
        imm_src_d    = 3'b000;
        rs1_used_d   = 1'b0;
        rs2_used_d   = 1'b0;
        w_dec.funct3 = w_funct3;
        case (w_opcode)
            OP_R: begin
                rs1_used_d      = 1'b1;
                rs2_used_d      = 1'b1;
                w_dec.reg_write = 1'b1;
                if (w_funct7 == 7'b0000001) begin
`ifdef MUL_EXT_EN
                    if (w_funct3[2]) w_bad = 1'b1;
                    else             w_dec.alu_ctrl = 4'b1011 + {2'b00, w_funct3[1:0]};
`else
                    w_bad = 1'b1;
`endif
                end else begin
                    w_dec.alu_ctrl = aluOp(w_funct3, w_funct7[5], 1'b1);
                end
            end
            OP_IALU: begin
                rs1_used_d      = 1'b1;
                w_dec.reg_write = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_dec.alu_ctrl  = aluOp(w_funct3, w_funct7[5], 1'b0);
            end
            OP_LOAD: begin
                rs1_used_d       = 1'b1;
                w_dec.reg_write  = 1'b1;
                w_dec.result_src = 2'b01;
                w_dec.alu_src    = 1'b1;
            end
            OP_STORE: begin
                imm_src_d       = 3'b001;
                rs1_used_d      = 1'b1;
                rs2_used_d      = 1'b1;
                w_dec.mem_write = 1'b1;
                w_dec.alu_src   = 1'b1;
            end
            OP_BRANCH: begin
                imm_src_d      = 3'b010;
                rs1_used_d     = 1'b1;
                rs2_used_d     = 1'b1;
                w_dec.branch   = 1'b1;
                w_dec.alu_ctrl = ALU_SUB;
            end
            OP_JAL: begin
                imm_src_d        = 3'b011;
                w_dec.reg_write  = 1'b1;
                w_dec.result_src = 2'b10;
                w_dec.jump       = 1'b1;
            end
            OP_JALR: begin
                rs1_used_d       = 1'b1;
                w_dec.reg_write  = 1'b1;
                w_dec.result_src = 2'b10;
                w_dec.jump       = 1'b1;
                w_dec.jalr       = 1'b1;
                w_dec.alu_src    = 1'b1;
            end
            OP_LUI: begin
                imm_src_d       = 3'b100;
                w_dec.reg_write = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_dec.alu_ctrl  = ALU_PASSB;
            end
            OP_AUIPC: begin
                imm_src_d       = 3'b100;
                w_dec.reg_write = 1'b1;
                w_dec.alu_src   = 1'b1;
            end
            default: w_bad = 1'b1;
        endcase
        if (w_bad) begin
            w_dec         = '0;
            w_dec.illegal = 1'b1;
        end
        w_dec.valid = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_eCtrl <= '0;
        else if (flush_e)  r_eCtrl <= '0;
        else if (!stall_e) r_eCtrl <= w_dec;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush_m) begin
            r_mValid     <= 1'b0;
            r_mIllegal   <= 1'b0;
            r_mRegWrite  <= 1'b0;
            r_mMemWrite  <= 1'b0;
            r_mResultSrc <= 2'b00;
        end else if (!stall_e) begin
            r_mValid     <= r_eCtrl.valid;
            r_mIllegal   <= r_eCtrl.illegal;
            r_mRegWrite  <= r_eCtrl.reg_write;
            r_mMemWrite  <= r_eCtrl.mem_write;
            r_mResultSrc <= r_eCtrl.result_src;
        end
    end

    assign w_retire = !stall_e && r_mValid && !r_mIllegal;

    // W and the retire counter advance together; a stall freezes both.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wRegWrite  <= 1'b0;
            r_wResultSrc <= 2'b00;
            r_retiredCnt <= '0;
        end else if (!stall_e) begin
            r_wRegWrite  <= r_mRegWrite;
            r_wResultSrc <= r_mResultSrc;
            if (w_retire) r_retiredCnt <= r_retiredCnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_cond = 1'b0;
        case (r_eCtrl.funct3)
            3'b000:  w_cond = zero_e;
            3'b001:  w_cond = !zero_e;
            3'b100:  w_cond = lt_e;
            3'b101:  w_cond = !lt_e;
            3'b110:  w_cond = ltu_e;
            3'b111:  w_cond = !ltu_e;
            default: w_cond = 1'b0;
        endcase
    end

    assign alu_ctrl_e   = r_eCtrl.alu_ctrl;
    assign alu_src_e    = r_eCtrl.alu_src;
    assign jalr_e       = r_eCtrl.jalr;
    assign result_src_e = r_eCtrl.result_src;
    assign illegal_e    = r_eCtrl.illegal;
    assign pc_src_e     = r_eCtrl.valid && (r_eCtrl.jump || (r_eCtrl.branch && w_cond));
    assign reg_write_m  = r_mRegWrite;
    assign mem_write_m  = r_mMemWrite;
    assign result_src_w = r_wResultSrc;
    assign reg_write_w  = r_wRegWrite;
    assign retired_cnt  = r_retiredCnt;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed self-checking bench for pipelined_control_unit; define MUL_EXT_EN to expect the multiply group.
module tb_pipelined_control_unit;

    localparam logic [31:0] ADD   = 32'h002081B3;
    localparam logic [31:0] SUB   = 32'h402081B3;
    localparam logic [31:0] LW    = 32'h0000A283;
    localparam logic [31:0] SW    = 32'h0050A223;
    localparam logic [31:0] BEQ   = 32'h00000063;
    localparam logic [31:0] BLT   = 32'h00004063;
    localparam logic [31:0] BR010 = 32'h00002063;
    localparam logic [31:0] BGEU  = 32'h00007063;
    localparam logic [31:0] JALR  = 32'h000100E7;
    localparam logic [31:0] MUL   = 32'h022081B3;
    localparam logic [31:0] DIV   = 32'h0220C1B3;
    localparam logic [31:0] ADDIM = 32'hFFF00093;
    localparam logic [31:0] SRAI  = 32'h4010D093;
    localparam logic [31:0] LUI   = 32'h000010B7;
    localparam logic [31:0] ILL   = 32'h00000000;

    logic        clk;
    logic        rst;
    logic [31:0] instr_d;
    logic        stall_e, flush_e, flush_m;
    logic        zero_e, lt_e, ltu_e;
    logic [2:0]  imm_src_d;
    logic        rs1_used_d, rs2_used_d;
    logic [3:0]  alu_ctrl_e;
    logic        alu_src_e, pc_src_e, jalr_e;
    logic [1:0]  result_src_e;
    logic        reg_write_m, mem_write_m;
    logic [1:0]  result_src_w;
    logic        reg_write_w, illegal_e;
    logic [31:0] retired_cnt;

    int errors = 0;
    int checks = 0;

    pipelined_control_unit #(.WIDTH(32), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .instr_d(instr_d),
        .stall_e(stall_e), .flush_e(flush_e), .flush_m(flush_m),
        .zero_e(zero_e), .lt_e(lt_e), .ltu_e(ltu_e),
        .imm_src_d(imm_src_d), .rs1_used_d(rs1_used_d), .rs2_used_d(rs2_used_d),
        .alu_ctrl_e(alu_ctrl_e), .alu_src_e(alu_src_e), .pc_src_e(pc_src_e),
        .jalr_e(jalr_e), .result_src_e(result_src_e),
        .reg_write_m(reg_write_m), .mem_write_m(mem_write_m),
        .result_src_w(result_src_w), .reg_write_w(reg_write_w),
        .illegal_e(illegal_e), .retired_cnt(retired_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one D-stage word plus hazard controls, then step one edge and settle.
    task automatic applyStimulus(input logic [31:0] instr, input logic stall, input logic fe, input logic fm);
        instr_d = instr;
        stall_e = stall;
        flush_e = fe;
        flush_m = fm;
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_alu"}, {28'd0, alu_ctrl_e}, 32'd0);
        checkOutput({tag, "_rsrcE"}, {30'd0, result_src_e}, 32'd0);
        checkOutput({tag, "_regwM"}, {31'd0, reg_write_m}, 32'd0);
        checkOutput({tag, "_regwW"}, {31'd0, reg_write_w}, 32'd0);
        checkOutput({tag, "_pcsrc"}, {31'd0, pc_src_e}, 32'd0);
        checkOutput({tag, "_ill"}, {31'd0, illegal_e}, 32'd0);
        checkOutput({tag, "_cnt"}, retired_cnt, 32'd0);
    endtask

    initial begin
        rst = 1'b1; instr_d = ADD;
        stall_e = 0; flush_e = 0; flush_m = 0;
        zero_e = 0; lt_e = 0; ltu_e = 0;
        @(posedge clk); @(posedge clk); #1;
        checkAllZero("reset");
        rst = 1'b0;

        // add flows through to W and retires
        #1 checkOutput("add_rs1", {31'd0, rs1_used_d}, 32'd1);
        checkOutput("add_rs2", {31'd0, rs2_used_d}, 32'd1);
        applyStimulus(ADD, 0, 0, 0);
        checkOutput("add_alu", {28'd0, alu_ctrl_e}, 32'h0);
        checkOutput("add_src", {31'd0, alu_src_e}, 32'd0);
        checkOutput("add_ill", {31'd0, illegal_e}, 32'd0);
        applyStimulus(ILL, 0, 0, 0);
        checkOutput("add_regwM", {31'd0, reg_write_m}, 32'd1);
        checkOutput("ill_E", {31'd0, illegal_e}, 32'd1);
        applyStimulus(ILL, 0, 0, 0);
        checkOutput("add_regwW", {31'd0, reg_write_w}, 32'd1);
        checkOutput("add_rsrcW", {30'd0, result_src_w}, 32'd0);
        checkOutput("add_cnt", retired_cnt, 32'd1);

        // lw then sw
        instr_d = LW; #1;
        checkOutput("lw_imm", {29'd0, imm_src_d}, 32'd0);
        checkOutput("lw_rs2", {31'd0, rs2_used_d}, 32'd0);
        applyStimulus(LW, 0, 0, 0);
        checkOutput("lw_rsrcE", {30'd0, result_src_e}, 32'h1);
        checkOutput("lw_src", {31'd0, alu_src_e}, 32'd1);
        instr_d = SW; #1;
        checkOutput("sw_rs2", {31'd0, rs2_used_d}, 32'd1);
        checkOutput("sw_imm", {29'd0, imm_src_d}, 32'd1);
        applyStimulus(SW, 0, 0, 0);
        checkOutput("lw_memwM", {31'd0, mem_write_m}, 32'd0);
        applyStimulus(ILL, 0, 0, 0);
        checkOutput("sw_memwM", {31'd0, mem_write_m}, 32'd1);
        checkOutput("lw_rsrcW", {30'd0, result_src_w}, 32'h1);
        checkOutput("lw_cnt", retired_cnt, 32'd2);
        applyStimulus(ILL, 0, 0, 0);
        checkOutput("sw_regwW", {31'd0, reg_write_w}, 32'd0);
        checkOutput("sw_cnt", retired_cnt, 32'd3);
        applyStimulus(ILL, 0, 0, 0);

        // branch conditions and jalr
        zero_e = 1;
        applyStimulus(BEQ, 0, 0, 0);
        checkOutput("beq_t", {31'd0, pc_src_e}, 32'd1);
        checkOutput("beq_alu", {28'd0, alu_ctrl_e}, 32'h1);
        zero_e = 0; #1;
        checkOutput("beq_nt", {31'd0, pc_src_e}, 32'd0);
        lt_e = 1;
        applyStimulus(BLT, 0, 0, 0);
        checkOutput("blt_t", {31'd0, pc_src_e}, 32'd1);
        lt_e = 0; #1;
        checkOutput("blt_nt", {31'd0, pc_src_e}, 32'd0);
        zero_e = 1; lt_e = 1; ltu_e = 1;
        applyStimulus(BR010, 0, 0, 0);
        checkOutput("br010", {31'd0, pc_src_e}, 32'd0);
        zero_e = 0; lt_e = 0; ltu_e = 0;
        applyStimulus(BGEU, 0, 0, 0);
        checkOutput("bgeu_t", {31'd0, pc_src_e}, 32'd1);
        ltu_e = 1; #1;
        checkOutput("bgeu_nt", {31'd0, pc_src_e}, 32'd0);
        ltu_e = 0;
        applyStimulus(JALR, 0, 0, 0);
        checkOutput("jalr_pc", {31'd0, pc_src_e}, 32'd1);
        checkOutput("jalr_e", {31'd0, jalr_e}, 32'd1);
        applyStimulus(ILL, 0, 0, 0);
        checkOutput("bgeu_cnt", retired_cnt, 32'd7);
        applyStimulus(ILL, 0, 0, 0);
        checkOutput("jalr_rsrcW", {30'd0, result_src_w}, 32'h2);
        checkOutput("jalr_regwW", {31'd0, reg_write_w}, 32'd1);
        checkOutput("jalr_cnt", retired_cnt, 32'd8);

        // stall freezes E/M/W, then flush_e overrides stall
        applyStimulus(ADD, 0, 0, 0);
        applyStimulus(LW, 0, 0, 0);
        checkOutput("pre_rsrcE", {30'd0, result_src_e}, 32'h1);
        checkOutput("pre_regwM", {31'd0, reg_write_m}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(SW, 1, 0, 0);
            checkOutput("stall_rsrcE", {30'd0, result_src_e}, 32'h1);
            checkOutput("stall_srcE", {31'd0, alu_src_e}, 32'd1);
            checkOutput("stall_regwM", {31'd0, reg_write_m}, 32'd1);
            checkOutput("stall_memwM", {31'd0, mem_write_m}, 32'd0);
            checkOutput("stall_regwW", {31'd0, reg_write_w}, 32'd0);
            checkOutput("stall_cnt", retired_cnt, 32'd8);
        end
        applyStimulus(SW, 1, 1, 0);
        checkOutput("fls_rsrcE", {30'd0, result_src_e}, 32'd0);
        checkOutput("fls_srcE", {31'd0, alu_src_e}, 32'd0);
        checkOutput("fls_illE", {31'd0, illegal_e}, 32'd0);
        checkOutput("fls_regwM", {31'd0, reg_write_m}, 32'd1);
        checkOutput("fls_cnt", retired_cnt, 32'd8);
        applyStimulus(ILL, 0, 0, 0);
        checkOutput("unst_regwM", {31'd0, reg_write_m}, 32'd0);
        checkOutput("unst_regwW", {31'd0, reg_write_w}, 32'd1);
        checkOutput("unst_cnt", retired_cnt, 32'd9);

        // flush_m kills an add in flight
        applyStimulus(ADD, 0, 0, 0);
        applyStimulus(ILL, 0, 0, 1);
        checkOutput("flm_regwM", {31'd0, reg_write_m}, 32'd0);
        applyStimulus(ILL, 0, 0, 0);
        checkOutput("flm_regwW", {31'd0, reg_write_w}, 32'd0);
        checkOutput("flm_cnt", retired_cnt, 32'd9);

        // multiply group and div (always illegal)
        applyStimulus(MUL, 0, 0, 0);
`ifdef MUL_EXT_EN
        checkOutput("mul_alu", {28'd0, alu_ctrl_e}, 32'hB);
        checkOutput("mul_ill", {31'd0, illegal_e}, 32'd0);
`else
        checkOutput("mul_alu", {28'd0, alu_ctrl_e}, 32'h0);
        checkOutput("mul_ill", {31'd0, illegal_e}, 32'd1);
`endif
        applyStimulus(DIV, 0, 0, 0);
        checkOutput("div_ill", {31'd0, illegal_e}, 32'd1);
        applyStimulus(ILL, 0, 0, 0);
`ifdef MUL_EXT_EN
        checkOutput("mul_regwW", {31'd0, reg_write_w}, 32'd1);
        checkOutput("mul_cnt", retired_cnt, 32'd10);
`else
        checkOutput("mul_regwW", {31'd0, reg_write_w}, 32'd0);
        checkOutput("mul_cnt", retired_cnt, 32'd9);
`endif
        applyStimulus(ILL, 0, 0, 0);
        checkOutput("div_regwW", {31'd0, reg_write_w}, 32'd0);

        // asynchronous reset mid-stream with adds in E and M
        applyStimulus(ADD, 0, 0, 0);
        applyStimulus(ADD, 0, 0, 0);
        #2 rst = 1'b1;
        #1 checkAllZero("areset");
        @(posedge clk); #1;
        checkAllZero("hreset");
        rst = 1'b0;
        applyStimulus(LW, 0, 0, 0);
        checkOutput("rel_rsrcE", {30'd0, result_src_e}, 32'h1);
        checkOutput("rel_regwM", {31'd0, reg_write_m}, 32'd0);
        checkOutput("rel_cnt", retired_cnt, 32'd0);

        // decode corner cases: addi with negative imm, srai, lui, sub
        applyStimulus(ADDIM, 0, 0, 0);
        checkOutput("addi_alu", {28'd0, alu_ctrl_e}, 32'h0);
        applyStimulus(SRAI, 0, 0, 0);
        checkOutput("srai_alu", {28'd0, alu_ctrl_e}, 32'h9);
        instr_d = LUI; #1;
        checkOutput("lui_rs1", {31'd0, rs1_used_d}, 32'd0);
        checkOutput("lui_imm", {29'd0, imm_src_d}, 32'h4);
        applyStimulus(LUI, 0, 0, 0);
        checkOutput("lui_alu", {28'd0, alu_ctrl_e}, 32'hA);
        checkOutput("lui_src", {31'd0, alu_src_e}, 32'd1);
        applyStimulus(SUB, 0, 0, 0);
        checkOutput("sub_alu", {28'd0, alu_ctrl_e}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
